// File: rtl/press_classifier_if.sv
// Button press classifier bus: raw button levels in,
// per-channel classification pulses and held levels out.
interface press_classifier_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] inc;
   logic [N_CH-1:0] inc_short;
   logic [N_CH-1:0] inc_long;
   logic [N_CH-1:0] inc_repeat;
   logic [N_CH-1:0] held;

   modport master (
      output inc,
      input  inc_short,
      input  inc_long,
      input  inc_repeat,
      input  held
   );

   modport slave (
      input  inc,
      output inc_short,
      output inc_long,
      output inc_repeat,
      output held
   );
endinterface

// File: rtl/press_classifier.sv
// Multi-channel button press classifier: synchronise, debounce,
// then classify each press as short, long (with auto-repeat) or noise.
module press_classifier #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 15,
   parameter int DEB_TICKS    = 4,
   parameter int MIN_TICKS    = 3,
   parameter int LONG_TICKS   = 450,
   parameter int REPEAT_TICKS = 1000
) (
   input  logic             clk_10000Hz,
   input  logic             rst,
   press_classifier_if.slave bus
);

   localparam int CNT_MAX_I = (2 ** CNT_W) - 1;

   localparam int REP_L =
      (REPEAT_TICKS == 0)           ? 0 :
      (REPEAT_TICKS - 1 > CNT_MAX_I) ? CNT_MAX_I :
                                       REPEAT_TICKS - 1;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_MAX_I);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_TICKS);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_L);
   localparam logic [7:0]       DEB_LAST = 8'(DEB_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HELD  = 2'd2
   } state_t;

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

      logic             s1;
      logic             s2;
      logic             deb_state;
      logic [7:0]       deb_cnt;
      state_t           state;
      logic [CNT_W-1:0] dur;
      logic [CNT_W-1:0] rep_cnt;
      logic             short_q;
      logic             long_q;
      logic             rep_q;
      logic             held_q;

      // Two-flop synchroniser for the asynchronous button level
      always_ff @(posedge clk_10000Hz or posedge rst) begin
         if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
         end else begin
            s1 <= bus.inc[ch];
            s2 <= s1;
         end
      end

      // Accept a level change only after DEB_TICKS consecutive
      // differing samples; any agreeing sample restarts the count
      always_ff @(posedge clk_10000Hz or posedge rst) begin
         if (rst) begin
            deb_state <= 1'b0;
            deb_cnt   <= 8'd0;
         end else if (s2 == deb_state) begin
            deb_cnt <= 8'd0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_state <= s2;
            deb_cnt   <= 8'd0;
         end else begin
            deb_cnt <= deb_cnt + 8'd1;
         end
      end

      // Press classification FSM; pulses are registered and last
      // exactly one cycle because they default low every edge
      always_ff @(posedge clk_10000Hz or posedge rst) begin
         if (rst) begin
            state   <= IDLE;
            dur     <= '0;
            rep_cnt <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            unique case (state)
               IDLE: begin
                  if (deb_state) begin
                     dur <= CNT_ONE;
                     if (LONG_TICKS == 1) begin
                        state   <= HELD;
                        rep_cnt <= '0;
                        held_q  <= 1'b1;
                     end else begin
                        state <= PRESS;
                     end
                  end
               end
               PRESS: begin
                  if (deb_state) begin
                     if (dur != CNT_MAX) begin
                        dur <= dur + CNT_ONE;
                     end
                     if (dur == LONG_M1) begin
                        state   <= HELD;
                        rep_cnt <= '0;
                        held_q  <= 1'b1;
                     end
                  end else begin
                     short_q <= (dur >= MIN_V);
                     state   <= IDLE;
                  end
               end
               HELD: begin
                  if (deb_state) begin
                     if (REPEAT_TICKS != 0) begin
                        if (rep_cnt == REP_LAST) begin
                           rep_q   <= 1'b1;
                           rep_cnt <= '0;
                        end else if (rep_cnt != CNT_MAX) begin
                           rep_cnt <= rep_cnt + CNT_ONE;
                        end
                     end
                  end else begin
                     long_q <= 1'b1;
                     held_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
               default: begin
                  state  <= IDLE;
                  held_q <= 1'b0;
               end
            endcase
         end
      end

      assign bus.inc_short[ch]  = short_q;
      assign bus.inc_long[ch]   = long_q;
      assign bus.inc_repeat[ch] = rep_q;
      assign bus.held[ch]       = held_q;

   end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier: short, long, repeat,
// bounce rejection, reset mid-press and concurrent channels.
module tb_press_classifier;

   localparam int N = 4;

   logic clk_10000Hz = 1'b0;
   logic rst;

   press_classifier_if #(.N_CH(N)) bus ();

   press_classifier dut (
      .clk_10000Hz (clk_10000Hz),
      .rst         (rst),
      .bus         (bus)
   );

   always #50 clk_10000Hz = ~clk_10000Hz;

   int checks = 0;
   int errors = 0;

   int ncyc;
   int c_short [N];
   int c_long  [N];
   int c_rep   [N];
   int c_held  [N];
   int t_short [N];
   int t_long  [N];
   int t_rep0  [N];
   int t_rep1  [N];
   int t_held  [N];
   int multi = 0;
   int xcnt  = 0;

   task automatic clear_counts();
      ncyc = 0;
      for (int c = 0; c < N; c++) begin
         c_short[c] = 0;
         c_long[c]  = 0;
         c_rep[c]   = 0;
         c_held[c]  = 0;
         t_short[c] = -1;
         t_long[c]  = -1;
         t_rep0[c]  = -1;
         t_rep1[c]  = -1;
         t_held[c]  = -1;
      end
   endtask

   // One clock: count the edge, then observe outputs on the falling edge
   task automatic step();
      int np;
      @(posedge clk_10000Hz);
      ncyc++;
      @(negedge clk_10000Hz);
      if ($isunknown({bus.inc_short, bus.inc_long,
                      bus.inc_repeat, bus.held}))
         xcnt++;
      for (int c = 0; c < N; c++) begin
         np = 0;
         if (bus.inc_short[c] === 1'b1) begin
            np++;
            c_short[c]++;
            if (t_short[c] < 0) t_short[c] = ncyc;
         end
         if (bus.inc_long[c] === 1'b1) begin
            np++;
            c_long[c]++;
            if (t_long[c] < 0) t_long[c] = ncyc;
         end
         if (bus.inc_repeat[c] === 1'b1) begin
            np++;
            c_rep[c]++;
            if (t_rep0[c] < 0) t_rep0[c] = ncyc;
            else if (t_rep1[c] < 0) t_rep1[c] = ncyc;
         end
         if (bus.held[c] === 1'b1) begin
            c_held[c]++;
            if (t_held[c] < 0) t_held[c] = ncyc;
         end
         if (np > 1) multi++;
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic test_reset();
      int tot;
      rst     = 1'b1;
      bus.inc = '0;
      clear_counts();
      steps(3);
      checks++;
      if ({bus.inc_short, bus.inc_long, bus.inc_repeat, bus.held}
          !== 16'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {bus.inc_short, bus.inc_long,
                   bus.inc_repeat, bus.held});
      end
      rst = 1'b0;
      clear_counts();
      steps(20);
      tot = 0;
      for (int c = 0; c < N; c++)
         tot += c_short[c] + c_long[c] + c_rep[c] + c_held[c];
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL reset_idle: got %0d active cycles want 0", tot);
      end
   endtask

   task automatic test_short();
      int other;
      clear_counts();
      bus.inc[0] = 1'b1;
      steps(100);
      bus.inc[0] = 1'b0;
      steps(30);
      checks++;
      if (c_short[0] !== 1) begin
         errors++;
         $display("FAIL short_count: got %0d want 1", c_short[0]);
      end
      checks++;
      if (t_short[0] !== 107) begin
         errors++;
         $display("FAIL short_time: got %0d want 107", t_short[0]);
      end
      other = 0;
      for (int c = 0; c < N; c++) begin
         other += c_long[c] + c_rep[c] + c_held[c];
         if (c != 0) other += c_short[c];
      end
      checks++;
      if (other !== 0) begin
         errors++;
         $display("FAIL short_others: got %0d want 0", other);
      end
   endtask

   task automatic test_bounce();
      int tot;
      clear_counts();
      bus.inc[1] = 1'b1;
      steps(2);
      bus.inc[1] = 1'b0;
      steps(30);
      tot = c_short[1] + c_long[1] + c_rep[1] + c_held[1];
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL bounce_2cyc: got %0d want 0", tot);
      end
      clear_counts();
      bus.inc[1] = 1'b1;
      steps(6);
      bus.inc[1] = 1'b0;
      steps(30);
      tot = c_long[1] + c_rep[1] + c_held[1];
      checks++;
      if (tot !== 0) begin
         errors++;
         $display("FAIL bounce_6cyc_long: got %0d want 0", tot);
      end
   endtask

   task automatic test_long();
      clear_counts();
      bus.inc[2] = 1'b1;
      steps(2500);
      bus.inc[2] = 1'b0;
      steps(30);
      checks++;
      if (t_held[2] !== 456) begin
         errors++;
         $display("FAIL held_rise: got %0d want 456", t_held[2]);
      end
      checks++;
      if (c_held[2] !== 2051) begin
         errors++;
         $display("FAIL held_len: got %0d want 2051", c_held[2]);
      end
      checks++;
      if (c_rep[2] !== 2) begin
         errors++;
         $display("FAIL rep_count: got %0d want 2", c_rep[2]);
      end
      checks++;
      if (t_rep0[2] !== 1456 || t_rep1[2] !== 2456) begin
         errors++;
         $display("FAIL rep_time: got %0d,%0d want 1456,2456",
                  t_rep0[2], t_rep1[2]);
      end
      checks++;
      if (c_long[2] !== 1 || t_long[2] !== 2507) begin
         errors++;
         $display("FAIL long_pulse: got n=%0d t=%0d want n=1 t=2507",
                  c_long[2], t_long[2]);
      end
      checks++;
      if (c_short[2] !== 0) begin
         errors++;
         $display("FAIL long_no_short: got %0d want 0", c_short[2]);
      end
   endtask

   task automatic test_glitch();
      clear_counts();
      for (int i = 0; i < 200; i++) begin
         bus.inc[0] = !(i >= 10 && i <= 190 && (i % 3) == 0);
         step();
      end
      bus.inc[0] = 1'b0;
      steps(30);
      checks++;
      if (c_short[0] !== 1 || t_short[0] !== 207) begin
         errors++;
         $display("FAIL glitch_short: got n=%0d t=%0d want n=1 t=207",
                  c_short[0], t_short[0]);
      end
      checks++;
      if (c_long[0] !== 0 || c_held[0] !== 0) begin
         errors++;
         $display("FAIL glitch_long: got %0d/%0d want 0/0",
                  c_long[0], c_held[0]);
      end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      bus.inc[3] = 1'b1;
      steps(300);
      rst = 1'b1;
      steps(3);
      checks++;
      if ({bus.inc_short, bus.inc_long, bus.inc_repeat, bus.held}
          !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h want 0",
                  {bus.inc_short, bus.inc_long,
                   bus.inc_repeat, bus.held});
      end
      checks++;
      if (c_short[3] !== 0 || c_long[3] !== 0) begin
         errors++;
         $display("FAIL mid_reset_pulse: got %0d/%0d want 0/0",
                  c_short[3], c_long[3]);
      end
      rst = 1'b0;
      steps(297);
      bus.inc[3] = 1'b0;
      steps(30);
      checks++;
      if (c_short[3] !== 1 || t_short[3] !== 607) begin
         errors++;
         $display("FAIL mid_reset_new: got n=%0d t=%0d want n=1 t=607",
                  c_short[3], t_short[3]);
      end
      checks++;
      if (c_long[3] !== 0 || c_held[3] !== 0) begin
         errors++;
         $display("FAIL mid_reset_long: got %0d/%0d want 0/0",
                  c_long[3], c_held[3]);
      end
   endtask

   task automatic test_concurrent();
      int reps;
      clear_counts();
      bus.inc = 4'b1111;
      for (int k = 1; k <= 1200; k++) begin
         step();
         if (k == 5)    bus.inc[2] = 1'b0;
         if (k == 50)   bus.inc[0] = 1'b0;
         if (k == 500)  bus.inc[1] = 1'b0;
         if (k == 1200) bus.inc[3] = 1'b0;
      end
      steps(30);
      checks++;
      if (c_short[0] !== 1 || t_short[0] !== 57 || c_long[0] !== 0) begin
         errors++;
         $display("FAIL conc_ch0: got s=%0d t=%0d l=%0d want 1 57 0",
                  c_short[0], t_short[0], c_long[0]);
      end
      checks++;
      if (c_long[1] !== 1 || t_long[1] !== 507 || c_short[1] !== 0) begin
         errors++;
         $display("FAIL conc_ch1: got l=%0d t=%0d s=%0d want 1 507 0",
                  c_long[1], t_long[1], c_short[1]);
      end
      checks++;
      if (t_held[1] !== 456) begin
         errors++;
         $display("FAIL conc_ch1_held: got %0d want 456", t_held[1]);
      end
      checks++;
      if (c_long[2] !== 0 || c_held[2] !== 0) begin
         errors++;
         $display("FAIL conc_ch2: got l=%0d h=%0d want 0 0",
                  c_long[2], c_held[2]);
      end
      checks++;
      if (c_long[3] !== 1 || t_long[3] !== 1207 || c_short[3] !== 0) begin
         errors++;
         $display("FAIL conc_ch3: got l=%0d t=%0d s=%0d want 1 1207 0",
                  c_long[3], t_long[3], c_short[3]);
      end
      reps = 0;
      for (int c = 0; c < N; c++) reps += c_rep[c];
      checks++;
      if (reps !== 0) begin
         errors++;
         $display("FAIL conc_repeat: got %0d want 0", reps);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (multi !== 0) begin
         errors++;
         $display("FAIL pulse_exclusive: got %0d overlaps want 0", multi);
      end
      checks++;
      if (xcnt !== 0) begin
         errors++;
         $display("FAIL unknown_outputs: got %0d cycles want 0", xcnt);
      end
   endtask

   initial begin
      rst     = 1'b1;
      bus.inc = '0;
      test_reset();
      test_short();
      test_bounce();
      test_long();
      test_glitch();
      test_reset_mid();
      test_concurrent();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
